// File: rtl/pxl_rdbuf_pkg.sv
// Shared constants for the pixel readout buffer: register offsets, STATUS/CTRL bit positions, entry width.
// Entry width widens to 32 bits when PXL_RDBUF_TIMESTAMP_EN is defined.
package pxl_rdbuf_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned ST_COUNT_W = 7;
    localparam int unsigned ST_EMPTY   = 8;
    localparam int unsigned ST_FULL    = 9;
    localparam int unsigned ST_OVF     = 10;
    localparam int unsigned ST_KDONE   = 11;
    localparam int unsigned ST_TS      = 12;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;
    localparam int unsigned CTRL_CLR_KD  = 2;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned TS_W  = 16;

`ifdef PXL_RDBUF_TIMESTAMP_EN
    localparam int unsigned DATA_W = PIX_W + TS_W;
    localparam logic        TS_EN  = 1'b1;
`else
    localparam int unsigned DATA_W = PIX_W;
    localparam logic        TS_EN  = 1'b0;
`endif

endpackage

// File: rtl/pxl_sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop (also when full) and a flush that overrides both.
// Head word is read combinationally from storage.
module pxl_sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees the slot a same-cycle push needs, so push is allowed when full only alongside a pop.
    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/pxl_readout_buffer.sv
// Queues pixel results on pxl_done rising edges and exposes them via a Wishbone register window.
// Optional capture timestamp per entry when PXL_RDBUF_TIMESTAMP_EN is defined.
module pxl_readout_buffer
    import pxl_rdbuf_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pxl_done_i,
    input  logic [15:0] pxl_data_i,
    input  logic        kernel_done_i,
    output logic        fifo_nempty_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              r_pxl_d;
    logic              r_kd_d;
    logic              r_ovf;
    logic              r_kd;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_nempty;

    logic              w_push;
    logic              w_kd_rise;
    logic              w_hit;
    logic              w_access;
    logic [1:0]        w_off;
    logic              w_pop;
    logic              w_ctrl_wr;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_clr_kd;
    logic              w_ovf_set;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_dout;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata_c;
    logic              w_unused_bits;

    assign w_unused_bits = &{1'b0, wbs_dat_i[31:3], wbs_sel_i[3:1], wbs_adr_i[1:0]};

    assign w_push    = pxl_done_i & ~r_pxl_d;
    assign w_kd_rise = kernel_done_i & ~r_kd_d;

    // Gating on ack keeps a held strobe from producing a second pop in the same transaction.
    assign w_hit     = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign w_access  = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_off     = wbs_adr_i[3:2];
    assign w_pop     = w_access & ~wbs_we_i & (w_off == REG_DATA);
    assign w_ctrl_wr = w_access & wbs_we_i & (w_off == REG_CTRL) & wbs_sel_i[0];
    assign w_flush   = w_ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign w_clr_ovf = w_ctrl_wr & wbs_dat_i[CTRL_CLR_OVF];
    assign w_clr_kd  = w_ctrl_wr & wbs_dat_i[CTRL_CLR_KD];
    assign w_ovf_set = w_push & w_full & ~w_pop & ~w_flush;

`ifdef PXL_RDBUF_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ts <= '0;
        else        r_ts <= r_ts + TS_W'(1);
    end

    assign w_din = {r_ts, pxl_data_i};
`else
    assign w_din = pxl_data_i;
`endif

    pxl_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Read mux reflects state before this access's own pop/CTRL effects.
    always_comb begin
        w_status                   = '0;
        w_status[ST_COUNT_W-1:0]   = ST_COUNT_W'(w_count);
        w_status[ST_EMPTY]         = w_empty;
        w_status[ST_FULL]          = w_full;
        w_status[ST_OVF]           = r_ovf;
        w_status[ST_KDONE]         = r_kd;
        w_status[ST_TS]            = TS_EN;
        w_rdata_c                  = '0;
        case (w_off)
            REG_DATA:   if (!w_empty) w_rdata_c = 32'(w_dout);
            REG_STATUS: w_rdata_c = w_status;
            default:    w_rdata_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pxl_d  <= 1'b0;
            r_kd_d   <= 1'b0;
            r_ovf    <= 1'b0;
            r_kd     <= 1'b0;
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_nempty <= 1'b0;
        end else begin
            r_pxl_d  <= pxl_done_i;
            r_kd_d   <= kernel_done_i;
            r_ack    <= w_access;
            r_nempty <= (w_count != '0);
            if (w_access) r_dat <= wbs_we_i ? 32'h0 : w_rdata_c;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_clr_ovf) r_ovf <= 1'b0;
            if (w_kd_rise)      r_kd  <= 1'b1;
            else if (w_clr_kd)  r_kd  <= 1'b0;
        end
    end

    assign wbs_ack_o     = r_ack;
    assign wbs_dat_o     = r_dat;
    assign fifo_nempty_o = r_nempty;

endmodule

// File: tb/tb_pxl_readout_buffer.sv
// Scoreboard bench for pxl_readout_buffer: queue-based reference model, directed plus random traffic.
// Honours PXL_RDBUF_TIMESTAMP_EN for the expected DATA upper half and STATUS[12].
module tb_pxl_readout_buffer;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h3000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        pxl_done_i = 1'b0;
    logic [15:0] pxl_data_i = 16'h0;
    logic        kernel_done_i = 1'b0;
    logic        fifo_nempty_o;

    pxl_readout_buffer #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .pxl_done_i    (pxl_done_i),
        .pxl_data_i    (pxl_data_i),
        .kernel_done_i (kernel_done_i),
        .fifo_nempty_o (fifo_nempty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] val;
        int          tag;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_id  = 0;
    exp_t        sb[$];
    logic [31:0] m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_kd  = 1'b0;
    logic [15:0] tb_cyc;

    // Cycles since reset release; equals the DUT's timestamp when timestamps are enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 16'h0;
        else        tb_cyc <= tb_cyc + 16'h1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && wbs_ack_o) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(wbs_ack_o), 32'h0);
            end else begin
                e = sb.pop_front();
                if (e.chk) check($sformatf("rdata#%0d", e.tag), wbs_dat_o, e.val);
            end
        end
    end

    function automatic logic [31:0] mk_entry(input logic [15:0] d);
`ifdef PXL_RDBUF_TIMESTAMP_EN
        return {tb_cyc, d};
`else
        return {16'h0, d};
`endif
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = 32'h0;
        s[6:0]  = 7'(m_q.size());
        s[8]    = (m_q.size() == 0);
        s[9]    = (m_q.size() == DEPTH);
        s[10]   = m_ovf;
        s[11]   = m_kd;
`ifdef PXL_RDBUF_TIMESTAMP_EN
        s[12]   = 1'b1;
`endif
        return s;
    endfunction

    task automatic model_push(input logic [15:0] d);
        if (m_q.size() < DEPTH) m_q.push_back(mk_entry(d));
        else                    m_ovf = 1'b1;
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_nempty();
        check("nempty", 32'(fifo_nempty_o), 32'(m_q.size() != 0));
    endtask

    // One Wishbone transaction, optionally with coincident pixel-done / kernel-done edges.
    task automatic wb_xfer(input bit we, input logic [1:0] off, input logic [31:0] wdata,
                           input logic [3:0] sel, input bit pxl, input logic [15:0] pdata,
                           input bit kd);
        exp_t e;
        bit   ctrl, flush, ovf_set, got;
        e.chk = !we;
        e.tag = xfer_id++;
        e.val = 32'h0;
        if (!we) begin
            if (off == 2'd0) begin
                if (m_q.size() > 0) e.val = m_q.pop_front();
            end else if (off == 2'd1) begin
                e.val = m_status();
            end
        end
        sb.push_back(e);
        ctrl    = we && off == 2'd2 && sel[0];
        flush   = ctrl && wdata[0];
        ovf_set = 1'b0;
        if (pxl && !flush) begin
            if (m_q.size() < DEPTH) m_q.push_back(mk_entry(pdata));
            else                    ovf_set = 1'b1;
        end
        if (flush) m_q.delete();
        if (ovf_set)                m_ovf = 1'b1;
        else if (ctrl && wdata[1])  m_ovf = 1'b0;
        if (kd)                     m_kd = 1'b1;
        else if (ctrl && wdata[2])  m_kd = 1'b0;

        wbs_cyc_i     = 1'b1;
        wbs_stb_i     = 1'b1;
        wbs_we_i      = we;
        wbs_adr_i     = BASE | {28'h0, off, 2'b00};
        wbs_dat_i     = wdata;
        wbs_sel_i     = sel;
        pxl_done_i    = pxl;
        pxl_data_i    = pdata;
        kernel_done_i = kd;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            cyc1();
            got = wbs_ack_o;
        end
        check("ack_seen", 32'(got), 32'h1);
        wbs_cyc_i     = 1'b0;
        wbs_stb_i     = 1'b0;
        wbs_we_i      = 1'b0;
        pxl_done_i    = 1'b0;
        kernel_done_i = 1'b0;
        cyc1();
        check("ack_pulse", 32'(wbs_ack_o), 32'h0);
    endtask

    task automatic rd(input logic [1:0] off);
        wb_xfer(1'b0, off, 32'h0, 4'hF, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic ctrl_wr(input logic [31:0] v);
        wb_xfer(1'b1, 2'd2, v, 4'h1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic pulse_pxl(input logic [15:0] d);
        model_push(d);
        pxl_done_i = 1'b1;
        pxl_data_i = d;
        cyc1();
        pxl_done_i = 1'b0;
        cyc1();
    endtask

    task automatic pulse_kd();
        m_kd = 1'b1;
        kernel_done_i = 1'b1;
        cyc1();
        kernel_done_i = 1'b0;
        cyc1();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wbs_ack_o), 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_nempty", 32'(fifo_nempty_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc1();

        rd(2'd1);
        pulse_pxl(16'h0011);
        pulse_pxl(16'h0022);
        pulse_pxl(16'h0033);
        check_nempty();
        rd(2'd1);
        repeat (4) rd(2'd0);
        rd(2'd1);
        check_nempty();

        // Held level: only one entry.
        model_push(16'hABCD);
        pxl_done_i = 1'b1;
        pxl_data_i = 16'hABCD;
        repeat (20) cyc1();
        pxl_done_i = 1'b0;
        cyc1();
        rd(2'd1);
        rd(2'd0);

        for (int i = 0; i < 9; i++) pulse_pxl(16'(16'h0100 + i));
        rd(2'd1);
        check_nempty();
        repeat (8) rd(2'd0);
        ctrl_wr(32'h2);
        rd(2'd1);

        // Full FIFO: push coincident with a DATA pop.
        for (int i = 0; i < 8; i++) pulse_pxl(16'(16'h0200 + i));
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 16'h0BEE, 1'b0);
        rd(2'd1);
        repeat (8) rd(2'd0);
        rd(2'd1);

        // Count-1: push and pop together.
        pulse_pxl(16'h0301);
        wb_xfer(1'b0, 2'd0, 32'h0, 4'hF, 1'b1, 16'h0302, 1'b0);
        rd(2'd1);
        rd(2'd0);

        pulse_kd();
        rd(2'd1);
        wb_xfer(1'b1, 2'd2, 32'h4, 4'h1, 1'b0, 16'h0, 1'b1);
        rd(2'd1);
        ctrl_wr(32'h4);
        rd(2'd1);

        for (int i = 0; i < 5; i++) pulse_pxl(16'(16'h0400 + i));
        ctrl_wr(32'h1);
        rd(2'd1);
        check_nempty();

        // Flush coincident with a push into a full FIFO.
        for (int i = 0; i < 8; i++) pulse_pxl(16'(16'h0500 + i));
        wb_xfer(1'b1, 2'd2, 32'h1, 4'h1, 1'b1, 16'h05FF, 1'b0);
        rd(2'd1);

        // Non-hit address: no ack, no pop.
        pulse_pxl(16'h0600);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h3000_0200;
        for (int i = 0; i < 3; i++) begin
            cyc1();
            check("nohit_ack", 32'(wbs_ack_o), 32'h0);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        cyc1();
        rd(2'd1);
        rd(2'd3);
        wb_xfer(1'b1, 2'd2, 32'h1, 4'hE, 1'b0, 16'h0, 1'b0);
        rd(2'd1);
        rd(2'd0);

        // Two captures ten cycles apart.
        pulse_pxl(16'h0701);
        repeat (8) cyc1();
        pulse_pxl(16'h0702);
        rd(2'd0);
        rd(2'd0);

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                pulse_pxl(16'($urandom));
            end else if (op < 9) begin
                wb_xfer(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                        32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                        ($urandom_range(0, 2) == 0), 16'($urandom),
                        ($urandom_range(0, 4) == 0));
            end else begin
                pulse_kd();
            end
            if (n % 16 == 0) check_nempty();
        end
        rd(2'd1);

        // Reset in the ack cycle: ack must drop asynchronously.
        pulse_pxl(16'h0800);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = BASE | 32'h4;
        cyc1();
        check("midrst_ack_before", 32'(wbs_ack_o), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_ack_after", 32'(wbs_ack_o), 32'h0);
        check("midrst_dat", wbs_dat_o, 32'h0);
        check("midrst_nempty", 32'(fifo_nempty_o), 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_kd  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc1();
        rd(2'd1);
        pulse_pxl(16'h0900);
        rd(2'd0);

        repeat (3) cyc1();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
